// File: rtl/wb_queue_pkg.sv
// Shared types and sizing for the writeback queue.
package wb_queue_pkg;
  localparam int kWbW     = 8;
  localparam int kWbD     = 4;
  localparam int kWbDepth = 4;

  typedef struct packed {
    logic [kWbD-1:0] addr;
    logic [kWbW-1:0] data;
  } wb_entry_t;

  // Producers must hold whenever fewer than two free slots remain.
  function automatic logic stall_for(input int depth, input int count);
    return (depth - count) < 32'sd2;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer with 0/1/2 pushes and 0/1 pop per cycle plus a pending-address
// compare across the valid entries.
module wb_fifo
  import wb_queue_pkg::*;
#(
  parameter int W     = kWbW,
  parameter int D     = kWbD,
  parameter int DEPTH = kWbDepth,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    push_n,
  input  logic [D-1:0]  push0_addr,
  input  logic [W-1:0]  push0_data,
  input  logic [D-1:0]  push1_addr,
  input  logic [W-1:0]  push1_data,
  input  logic          pop,
  output logic [D-1:0]  head_addr,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  input  logic [D-1:0]  chk_addr,
  output logic          chk_hit
);
  logic [D-1:0]  addr_r [DEPTH];
  logic [W-1:0]  data_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] wr_ptr1_s;
  logic [CW-1:0] count_r;
  logic [AW-1:0] off_s [DEPTH];

  assign wr_ptr1_s = wr_ptr_r + AW'(1);
  assign head_addr = addr_r[rd_ptr_r];
  assign head_data = data_r[rd_ptr_r];
  assign count     = count_r;

  // Entry storage; the first push is the older instruction and lands at wr_ptr.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      addr_r[wr_ptr_r] <= push0_addr;
      data_r[wr_ptr_r] <= push0_data;
    end
    if (push_n == 2'd2) begin
      addr_r[wr_ptr1_s] <= push1_addr;
      data_r[wr_ptr1_s] <= push1_data;
    end
  end

  // Pointers wrap naturally at AW bits since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_r + AW'(pop);
      wr_ptr_r <= wr_ptr_r + AW'(push_n);
      count_r  <= count_r + CW'(push_n) - CW'(pop);
    end
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s[i] = AW'(i) - rd_ptr_r;
      chk_hit  = chk_hit | ((CW'(off_s[i]) < count_r) & (addr_r[i] == chk_addr));
    end
  end
endmodule

// File: rtl/wb_queue_chk.sv
// Structural checks for the writeback queue.
module wb_queue_chk #(
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          reset,
  input logic [1:0]    push_n,
  input logic [CW-1:0] count
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !((push_n != 2'd0) && (count == CW'(DEPTH))));
endmodule

// File: rtl/wb_queue.sv
// Writeback queue: accepts ALU/load results, drains one per cycle to the RF port.
// Optional WB_BYPASS_EN lets the oldest offer skip an empty queue (latency 1).
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int W     = kWbW,
  parameter int D     = kWbD,
  parameter int DEPTH = kWbDepth
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         alu_valid,
  input  logic [D-1:0] alu_addr,
  input  logic [W-1:0] alu_data,
  input  logic         ld_valid,
  input  logic [D-1:0] ld_addr,
  input  logic [W-1:0] ld_data,
  output logic         stall,
  output logic         write_en,
  output logic [D-1:0] waddr,
  output logic [W-1:0] wdata,
  input  logic [D-1:0] chk_addr,
  output logic         chk_hit
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          ld_acc_s;
  logic          alu_acc_s;
  logic          pop_s;
  logic          byp_s;
  logic [1:0]    push_n_s;
  logic [D-1:0]  push0_addr_s;
  logic [W-1:0]  push0_data_s;
  logic [D-1:0]  byp_addr_s;
  logic [W-1:0]  byp_data_s;
  logic [D-1:0]  head_addr_s;
  logic [W-1:0]  head_data_s;
  logic [CW-1:0] count_s;
  logic          fifo_hit_s;

  assign stall     = stall_for(DEPTH, int'(count_s));
  assign ld_acc_s  = ld_valid & ~stall;
  assign alu_acc_s = alu_valid & ~stall;
  assign pop_s     = (count_s != CW'(0));

`ifdef WB_BYPASS_EN
  assign byp_s = (count_s == CW'(0)) & (ld_acc_s | alu_acc_s);
`else
  assign byp_s = 1'b0;
`endif

  assign byp_addr_s = ld_acc_s ? ld_addr : alu_addr;
  assign byp_data_s = ld_acc_s ? ld_data : alu_data;

  // Enqueue selection: the load is older and goes first; a bypassed offer is not queued.
  always_comb begin
    push_n_s     = 2'd0;
    push0_addr_s = alu_addr;
    push0_data_s = alu_data;
    if (byp_s) begin
      push_n_s = {1'b0, ld_acc_s & alu_acc_s};
    end else if (ld_acc_s) begin
      push_n_s     = {1'b0, alu_acc_s} + 2'd1;
      push0_addr_s = ld_addr;
      push0_data_s = ld_data;
    end else begin
      push_n_s = {1'b0, alu_acc_s};
    end
  end

  wb_fifo #(.W(W), .D(D), .DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .reset      (reset),
    .push_n     (push_n_s),
    .push0_addr (push0_addr_s),
    .push0_data (push0_data_s),
    .push1_addr (alu_addr),
    .push1_data (alu_data),
    .pop        (pop_s),
    .head_addr  (head_addr_s),
    .head_data  (head_data_s),
    .count      (count_s),
    .chk_addr   (chk_addr),
    .chk_hit    (fifo_hit_s)
  );

  // Output registers; address/data hold when no write is issued.
  always_ff @(posedge CLK) begin
    if (reset) begin
      write_en <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else if (pop_s) begin
      write_en <= 1'b1;
      waddr    <= head_addr_s;
      wdata    <= head_data_s;
    end else if (byp_s) begin
      write_en <= 1'b1;
      waddr    <= byp_addr_s;
      wdata    <= byp_data_s;
    end else begin
      write_en <= 1'b0;
    end
  end

  assign chk_hit = fifo_hit_s | (write_en & (waddr == chk_addr));

  wb_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk    (CLK),
    .reset  (reset),
    .push_n (push_n_s),
    .count  (count_s)
  );
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: vector table, scoreboard, corner sequences.
module tb_wb_queue;
  import wb_queue_pkg::*;

  localparam int DEPTH = kWbDepth;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, ld_valid;
  logic [3:0] alu_addr, ld_addr, chk_addr;
  logic [7:0] alu_data, ld_data;
  logic       stall, write_en, chk_hit;
  logic [3:0] waddr;
  logic [7:0] wdata;

  always #5 clk = ~clk;

  wb_queue dut (
    .CLK(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .stall(stall), .write_en(write_en), .waddr(waddr), .wdata(wdata),
    .chk_addr(chk_addr), .chk_hit(chk_hit)
  );

  typedef struct {
    logic lv; logic [3:0] la; logic [7:0] ldd;
    logic av; logic [3:0] aa; logic [7:0] ad;
    logic [3:0] ca;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  we_nb; logic hit_nb;
    logic  we_b;  logic hit_b;
  } vec_t;

  wb_entry_t sb[$];
  int mq = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic lv, input logic [3:0] la, input logic [7:0] ldd,
                               input logic av, input logic [3:0] aa, input logic [7:0] ad,
                               input logic [3:0] ca);
    stim_t s;
    s.lv = lv; s.la = la; s.ldd = ldd; s.av = av; s.aa = aa; s.ad = ad; s.ca = ca;
    return s;
  endfunction

  // Drive one cycle of offers, update the model, check outputs on the next negedge.
  task automatic step(input stim_t s, output logic acc_l, output logic acc_a);
    wb_entry_t e;
    logic m_stall, pop, byp, mwe, exp_hit;
    int n_acc;
    ld_valid = s.lv; ld_addr = s.la; ld_data = s.ldd;
    alu_valid = s.av; alu_addr = s.aa; alu_data = s.ad;
    chk_addr = s.ca;
    m_stall = (DEPTH - mq) < 2;
    acc_l = s.lv && !m_stall;
    acc_a = s.av && !m_stall;
    if (acc_l) begin e.addr = s.la; e.data = s.ldd; sb.push_back(e); end
    if (acc_a) begin e.addr = s.aa; e.data = s.ad; sb.push_back(e); end
    n_acc = int'(acc_l) + int'(acc_a);
    pop = (mq > 0);
    byp = BYP && (mq == 0) && (n_acc > 0);
    mwe = pop || byp;
    mq = mq + n_acc - int'(pop) - int'(byp);
    @(posedge clk);
    @(negedge clk);
    cmp("stall", stall, int'((DEPTH - mq) < 2));
    cmp("write_en", write_en, mwe);
    exp_hit = 1'b0;
    foreach (sb[i]) if (sb[i].addr == s.ca) exp_hit = 1'b1;
    cmp("chk_hit", chk_hit, exp_hit);
    if (mwe && sb.size() > 0) begin
      e = sb.pop_front();
      cmp("waddr", waddr, e.addr);
      cmp("wdata", wdata, e.data);
    end
  endtask

  task automatic do_reset(input logic [3:0] ca);
    ld_valid = 1'b0; alu_valid = 1'b0; chk_addr = ca;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    mq = 0;
    @(negedge clk);
    cmp("rst_we", write_en, 0);
    cmp("rst_stall", stall, 0);
    cmp("rst_hit", chk_hit, 0);
    cmp("rst_waddr", waddr, 0);
    cmp("rst_wdata", wdata, 0);
  endtask

  vec_t tbl[7];
  logic al, aa_ok;
  int li, ai;

  initial begin
    ld_valid = 1'b0; ld_addr = 4'd0; ld_data = 8'd0;
    alu_valid = 1'b0; alu_addr = 4'd0; alu_data = 8'd0;
    chk_addr = 4'd0; reset = 1'b1;
    do_reset(4'd0);

    // Single ALU write latency, then a dual offer to the same register.
    tbl[0] = '{mk(0, 0, 0,      1, 3, 8'h5A, 3), 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{mk(0, 0, 0,      0, 0, 0,     3), 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{mk(0, 0, 0,      0, 0, 0,     3), 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{mk(1, 2, 8'h11,  1, 2, 8'h22, 2), 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{mk(0, 0, 0,      0, 0, 0,     2), 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{mk(0, 0, 0,      0, 0, 0,     2), 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{mk(0, 0, 0,      0, 0, 0,     2), 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].s, al, aa_ok);
      cmp($sformatf("tbl%0d_we", i), write_en, BYP ? tbl[i].we_b : tbl[i].we_nb);
      cmp($sformatf("tbl%0d_hit", i), chk_hit, BYP ? tbl[i].hit_b : tbl[i].hit_nb);
      if ((BYP && i == 4) || (!BYP && i == 5)) cmp("r2_last", wdata, 8'h22);
    end

    // Hazard check: r5 pending vs an unrelated r6 probe.
    step(mk(0, 0, 0, 1, 5, 8'hC5, 5), al, aa_ok);
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 5), al, aa_ok);
    step(mk(0, 0, 0, 1, 5, 8'hC6, 6), al, aa_ok);
    cmp("hit6_a", chk_hit, 0);
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 6), al, aa_ok);
      cmp("hit6_b", chk_hit, 0);
    end

    // Both producers offering continuously; held offers retry under stall.
    li = 0; ai = 0;
    for (int c = 0; c < 60 && (li < 10 || ai < 10); c++) begin
      step(mk(li < 10, 4'(li), 8'(16 + li), ai < 10, 4'(15 - ai), 8'(160 + ai), 5), al, aa_ok);
      if (al) li++;
      if (aa_ok) ai++;
    end
    cmp("stress_ld_accepted", li, 10);
    cmp("stress_alu_accepted", ai, 10);
    for (int c = 0; c < 12 && sb.size() > 0; c++) step(mk(0, 0, 0, 0, 0, 0, 5), al, aa_ok);
    cmp("stress_drained", sb.size(), 0);

    // Reset with entries queued: nothing stale may come out afterwards.
    for (int k = 0; k < 6 && mq < 3; k++)
      step(mk(1, 7, 8'(k), 1, 8, 8'(64 + k), 7), al, aa_ok);
    cmp("fill_reached", int'(mq >= 3), 1);
    do_reset(4'd7);
    for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 0, 0, 0, 7), al, aa_ok);

    // Nine spaced offers cycle the pointers past the wrap twice.
    for (int i = 0; i < 9; i++) begin
      step(mk(0, 0, 0, 1, 4'(i + 1), 8'(128 + i), 4'(i + 1)), al, aa_ok);
      step(mk(0, 0, 0, 0, 0, 0, 4'(i + 1)), al, aa_ok);
    end
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0), al, aa_ok);
    cmp("wrap_idle_stall", stall, 0);
    cmp("wrap_idle_we", write_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
